// File: rtl/id_pkg.sv
// Shared lexer definitions: identifier-scanner state encoding and the ASCII
// range bounds used by the character classifier.
package id_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ALPHA = 3'd1,
        DIGIT = 3'd2,
        OVF   = 3'd3,
        JUNK  = 3'd4
    } state_e;

    localparam logic [7:0] ASCII_UC_A = 8'h41;
    localparam logic [7:0] ASCII_UC_Z = 8'h5A;
    localparam logic [7:0] ASCII_LC_A = 8'h61;
    localparam logic [7:0] ASCII_LC_Z = 8'h7A;
    localparam logic [7:0] ASCII_0    = 8'h30;
    localparam logic [7:0] ASCII_9    = 8'h39;
    localparam logic [7:0] ASCII_US   = 8'h5F;

endpackage

// File: rtl/char_class.sv
// Combinational byte classifier shared by the lexer blocks: letter / digit.
// Anything that is neither is treated as a delimiter by the consumers.
module char_class
    import id_pkg::*;
#(
    parameter bit ALLOW_US = 1'b1
) (
    input  logic [7:0] char_i,
    output logic       is_l,
    output logic       is_d
);

    logic upper;
    logic lower;
    logic under;

    assign upper = (char_i >= ASCII_UC_A) && (char_i <= ASCII_UC_Z);
    assign lower = (char_i >= ASCII_LC_A) && (char_i <= ASCII_LC_Z);
    assign under = ALLOW_US && (char_i == ASCII_US);

    assign is_l = upper || lower || under;
    assign is_d = (char_i >= ASCII_0) && (char_i <= ASCII_9);

endmodule

// File: rtl/id_scanner.sv
// Identifier scanner: tracks letter-led alphanumeric tokens in a byte stream,
// pulses tok_done with length/overflow on each delimiter and counts tokens.
//
//   state | meaning
//   IDLE  | between tokens
//   ALPHA | inside identifier, last accepted char a letter
//   DIGIT | inside identifier, last accepted char a digit
//   OVF   | identifier longer than MAX_LEN, swallowing the rest
//   JUNK  | number literal or digit-led word, no emission
module id_scanner
    import id_pkg::*;
#(
    parameter int MAX_LEN  = 16,
    parameter int LEN_W    = 5,
    parameter int CNT_W    = 8,
    parameter bit ALLOW_US = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             char_valid,
    input  logic [7:0]       char_i,
    input  logic             clr_cnt,
    output logic             in_id,
    output logic             out,
    output logic             tok_done,
    output logic [LEN_W-1:0] tok_len,
    output logic             tok_ovf,
    output logic [CNT_W-1:0] tok_cnt
);

    if ((MAX_LEN < 1) || (MAX_LEN > (1 << LEN_W) - 1)) begin : g_bad_max_len
        $error("id_scanner: MAX_LEN must lie in 1..2^LEN_W-1");
    end

    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

    logic             is_l;
    logic             is_d;
    state_e           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             emit;
    logic [LEN_W-1:0] emit_len;
    logic             emit_ovf;
    logic             tok_done_q;
    logic [LEN_W-1:0] tok_len_q;
    logic             tok_ovf_q;
    logic [CNT_W-1:0] tok_cnt_q, tok_cnt_d;

    char_class #(.ALLOW_US(ALLOW_US)) u_char_class (
        .char_i (char_i),
        .is_l   (is_l),
        .is_d   (is_d)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        emit     = 1'b0;
        emit_len = len_q;
        emit_ovf = 1'b0;
        if (char_valid) begin
            case (state_q)
                IDLE: begin
                    if (is_l) begin
                        state_d = ALPHA;
                        len_d   = LEN_W'(1);
                    end else if (is_d) begin
                        state_d = JUNK;
                    end
                end
                ALPHA, DIGIT: begin
                    if (is_l || is_d) begin
                        if (len_q == MAX_LEN_L) begin
                            state_d = OVF;
                        end else begin
                            state_d = is_l ? ALPHA : DIGIT;
                            len_d   = len_q + LEN_W'(1);
                        end
                    end else begin
                        state_d = IDLE;
                        len_d   = '0;
                        emit    = 1'b1;
                    end
                end
                OVF: begin
                    if (!(is_l || is_d)) begin
                        state_d  = IDLE;
                        len_d    = '0;
                        emit     = 1'b1;
                        emit_len = MAX_LEN_L;
                        emit_ovf = 1'b1;
                    end
                end
                JUNK: begin
                    if (!(is_l || is_d)) state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                    len_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        in_id = (state_q == ALPHA) || (state_q == DIGIT) || (state_q == OVF);
        out   = (state_q == DIGIT);
    end

    // A clear coinciding with an emission still counts that token.
    always_comb begin
        if (clr_cnt) tok_cnt_d = CNT_W'(emit);
        else         tok_cnt_d = tok_cnt_q + CNT_W'(emit);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tok_done_q <= 1'b0;
            tok_len_q  <= '0;
            tok_ovf_q  <= 1'b0;
            tok_cnt_q  <= '0;
        end else begin
            tok_done_q <= emit;
            tok_cnt_q  <= tok_cnt_d;
            if (emit) begin
                tok_len_q <= emit_len;
                tok_ovf_q <= emit_ovf;
            end
        end
    end

    assign tok_done = tok_done_q;
    assign tok_len  = tok_len_q;
    assign tok_ovf  = tok_ovf_q;
    assign tok_cnt  = tok_cnt_q;

endmodule

// File: tb/tb_id_scanner.sv
// Bench for id_scanner: two configurations driven in parallel and compared
// every cycle against a run-length reference model of the token rules.
module tb_id_scanner;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       char_valid;
    logic [7:0] c_in;
    logic       clr_cnt;

    logic       in_id_a, out_a, done_a, ovf_a;
    logic [2:0] len_a;
    logic [1:0] cnt_a;
    logic       in_id_b, out_b, done_b, ovf_b;
    logic [4:0] len_b;
    logic [7:0] cnt_b;

    int n_checks = 0;
    int n_fail   = 0;

    // Instance 0: short tokens, 2-bit counter, '_' is a letter.
    // Instance 1: default sizes, '_' is a delimiter.
    int max_len [2] = '{4, 16};
    int cnt_w   [2] = '{2, 8};
    bit allow_us[2] = '{1'b1, 1'b0};

    int run    [2];
    bit first_l[2];
    bit last_d [2];
    bit m_done [2];
    int m_len  [2];
    bit m_ovf  [2];
    int m_cnt  [2];
    int mode;

    always #5 clk = ~clk;

    id_scanner #(.MAX_LEN(4), .LEN_W(3), .CNT_W(2), .ALLOW_US(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .char_valid(char_valid), .char_i(c_in),
        .clr_cnt(clr_cnt), .in_id(in_id_a), .out(out_a), .tok_done(done_a),
        .tok_len(len_a), .tok_ovf(ovf_a), .tok_cnt(cnt_a)
    );

    id_scanner #(.MAX_LEN(16), .LEN_W(5), .CNT_W(8), .ALLOW_US(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .char_valid(char_valid), .char_i(c_in),
        .clr_cnt(clr_cnt), .in_id(in_id_b), .out(out_b), .tok_done(done_b),
        .tok_len(len_b), .tok_ovf(ovf_b), .tok_cnt(cnt_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit cls_l(int i, logic [7:0] c);
        return (c >= "A" && c <= "Z") || (c >= "a" && c <= "z") || (allow_us[i] && c == "_");
    endfunction

    function automatic bit cls_d(logic [7:0] c);
        return c >= "0" && c <= "9";
    endfunction

    // A token is the run of letters/digits since the last delimiter; it is
    // an identifier when its first char was a letter.
    function automatic void model_step(int i);
        bit l, d, emit;
        l    = cls_l(i, c_in);
        d    = cls_d(c_in);
        emit = 1'b0;
        if (!rst_n) begin
            run[i] = 0; first_l[i] = 0; last_d[i] = 0;
            m_done[i] = 0; m_len[i] = 0; m_ovf[i] = 0; m_cnt[i] = 0;
            return;
        end
        if (char_valid) begin
            if (l || d) begin
                if (run[i] == 0) first_l[i] = l;
                if (run[i] < 1000) run[i]++;
                last_d[i] = d;
            end else begin
                if (run[i] > 0 && first_l[i]) begin
                    emit     = 1'b1;
                    m_len[i] = (run[i] > max_len[i]) ? max_len[i] : run[i];
                    m_ovf[i] = run[i] > max_len[i];
                end
                run[i]     = 0;
                first_l[i] = 0;
            end
        end
        m_done[i] = emit;
        if (clr_cnt) m_cnt[i] = emit ? 1 : 0;
        else         m_cnt[i] = (m_cnt[i] + int'(emit)) % (1 << cnt_w[i]);
    endfunction

    function automatic bit exp_in_id(int i);
        return run[i] > 0 && first_l[i];
    endfunction

    function automatic bit exp_out(int i);
        return exp_in_id(i) && last_d[i] && run[i] <= max_len[i];
    endfunction

    task automatic compare_all();
        check("a.in_id",    32'(in_id_a), 32'(exp_in_id(0)));
        check("a.out",      32'(out_a),   32'(exp_out(0)));
        check("a.tok_done", 32'(done_a),  32'(m_done[0]));
        check("a.tok_len",  32'(len_a),   32'(m_len[0]));
        check("a.tok_ovf",  32'(ovf_a),   32'(m_ovf[0]));
        check("a.tok_cnt",  32'(cnt_a),   32'(m_cnt[0]));
        check("b.in_id",    32'(in_id_b), 32'(exp_in_id(1)));
        check("b.out",      32'(out_b),   32'(exp_out(1)));
        check("b.tok_done", 32'(done_b),  32'(m_done[1]));
        check("b.tok_len",  32'(len_b),   32'(m_len[1]));
        check("b.tok_ovf",  32'(ovf_b),   32'(m_ovf[1]));
        check("b.tok_cnt",  32'(cnt_b),   32'(m_cnt[1]));
    endtask

    task automatic step();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        compare_all();
    endtask

    task automatic idle(int n);
        char_valid = 1'b0;
        repeat (n) step();
    endtask

    task automatic send(logic [7:0] c);
        char_valid = 1'b1;
        c_in       = c;
        step();
        char_valid = 1'b0;
    endtask

    task automatic send_str(string s);
        for (int k = 0; k < s.len(); k++) send(8'(s[k]));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n      = 1'b0;
        char_valid = 1'b0;
        c_in       = 8'h00;
        clr_cnt    = 1'b0;

        do_reset();
        check("rst.in_id", 32'(in_id_b), 32'd0);
        check("rst.cnt",   32'(cnt_b),   32'd0);

        send("a"); idle(3); send("b"); idle(3); send("1"); idle(3);
        check("hold.out",  32'(out_b),  32'd1);
        check("hold.done", 32'(done_b), 32'd0);

        do_reset();
        send_str("x9y ");
        check("basic.done", 32'(done_b), 32'd1);
        check("basic.len",  32'(len_b),  32'd3);
        check("basic.cnt",  32'(cnt_b),  32'd1);
        idle(1);
        check("basic.pulse", 32'(done_b), 32'd0);

        do_reset();
        send_str("12ab;c;");
        check("junk.len", 32'(len_b), 32'd1);
        check("junk.cnt", 32'(cnt_b), 32'd1);

        do_reset();
        send_str("abcdefg ");
        check("ovf.len", 32'(len_a), 32'd4);
        check("ovf.ovf", 32'(ovf_a), 32'd1);
        send_str("ab ");
        check("ovf.next_len", 32'(len_a), 32'd2);
        check("ovf.next_ovf", 32'(ovf_a), 32'd0);

        do_reset();
        send_str("_a1 ");
        check("us1.len", 32'(len_a), 32'd3);
        check("us0.len", 32'(len_b), 32'd2);

        do_reset();
        for (int k = 0; k < 5; k++) send_str("a ");
        check("wrap.cnt", 32'(cnt_a), 32'd1);
        send_str("ab");
        clr_cnt = 1'b1;
        send(" ");
        clr_cnt = 1'b0;
        check("clr_emit.cnt", 32'(cnt_a), 32'd1);

        do_reset();
        send_str("abc");
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        send(" ");
        check("rst_mid.done", 32'(done_a), 32'd0);
        check("rst_mid.cnt",  32'(cnt_a),  32'd0);

        mode = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            int r;
            if (cyc % 64 == 0) mode = $urandom_range(0, 1);
            char_valid = ($urandom_range(0, 9) < 7);
            clr_cnt    = ($urandom_range(0, 99) < 3);
            rst_n      = ($urandom_range(0, 199) != 0);
            r = $urandom_range(0, (mode == 1) ? 39 : 9);
            if (r > 9) r = $urandom_range(0, 6);
            case (r)
                0, 1:    c_in = 8'("a") + 8'($urandom_range(0, 25));
                2, 3:    c_in = 8'("A") + 8'($urandom_range(0, 25));
                4, 5:    c_in = 8'("0") + 8'($urandom_range(0, 9));
                6:       c_in = 8'("_");
                7:       c_in = 8'(" ");
                8:       c_in = 8'(";");
                default: c_in = 8'($urandom_range(0, 255));
            endcase
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
